vertex_transform_unit: RTL and testbench

Synthesizable, streaming 4x4 fixed-point matrix-vector transform for the geometry front end. It accepts one homogeneous vertex (x, y, z, w) per handshake and multiplies it by a double-buffered 4x4 transform matrix. Accumulation is sequential, with one column per clock on four parallel multipliers. The result is emitted on a ready/valid output as M-bit integer screen-space components, with selectable saturation or wrap.

---
 rtl/vertex_transform_unit.sv | 165 ++++++++++++++++
 tb/tb_vertex_transform_unit.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vertex_transform_unit.sv
`default_nettype none
// ============================================================================
// Module   : vertex_transform_unit
// Brief    : Streaming 4x4 fixed-point matrix * homogeneous vertex transform
//            with a double-buffered matrix and saturating/wrapping output.
// Revision : 1.0 - initial release
// ============================================================================
module vertex_transform_unit #(
    parameter int M        = 11,
    parameter int N        = 7,
    parameter bit SATURATE = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mat_we,
    input  logic [3:0]             mat_addr,
    input  logic [M+N-1:0]         mat_data,
    input  logic                   mat_commit,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*(M+N)-1:0]     in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*M-1:0]         out_data,
    output logic                   busy,
    output logic                   ovf
);

    localparam int W  = M + N;
    localparam int PW = 2 * W;
    localparam int AW = PW + 2;
    localparam int SW = AW - 2 * N;

    localparam logic signed [W-1:0]  c_one = W'(2 ** N);
    localparam logic signed [SW-1:0] c_max = SW'((2 ** (M - 1)) - 1);
    localparam logic signed [SW-1:0] c_min = ~c_max;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                r_state;
    logic [2:0]            r_k;
    logic                  r_commit_pending;
    logic                  r_out_valid;
    logic [4*M-1:0]        r_out_data;
    logic                  r_ovf;
    logic signed [W-1:0]   r_shadow [16];
    logic signed [W-1:0]   r_active [16];
    logic signed [W-1:0]   r_vec    [4];
    logic signed [AW-1:0]  r_acc    [4];

    logic [1:0]            w_col;
    logic signed [AW-1:0]  w_prod_ext [4];
    logic [3:0]            w_ovf;
    logic [4*M-1:0]        w_result;
    logic                  w_copy;

    assign w_col     = r_k[1:0];
    assign w_copy    = (r_state == S_IDLE) && r_commit_pending;
    assign in_ready  = (r_state == S_IDLE) && !r_commit_pending && !rst;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = (r_state != S_IDLE) || r_commit_pending;
    assign ovf       = r_ovf;

    // One multiplier per output row; the shifted view drops the 2N fraction bits (floor).
    for (genvar r = 0; r < 4; r++) begin : g_row
        logic signed [PW-1:0] w_coef;
        logic signed [PW-1:0] w_comp;
        logic signed [PW-1:0] w_prod;
        logic signed [SW-1:0] w_shifted;
        logic                 w_hi;
        logic                 w_lo;

        assign w_coef        = PW'(r_active[{2'(r), w_col}]);
        assign w_comp        = PW'(r_vec[w_col]);
        assign w_prod        = w_coef * w_comp;
        assign w_prod_ext[r] = {{2{w_prod[PW-1]}}, w_prod};
        assign w_shifted     = r_acc[r][AW-1:2*N];
        assign w_hi          = w_shifted > c_max;
        assign w_lo          = w_shifted < c_min;
        assign w_ovf[r]      = w_hi | w_lo;
        assign w_result[r*M +: M] = (SATURATE && w_hi) ? c_max[M-1:0] :
                                    (SATURATE && w_lo) ? c_min[M-1:0] :
                                    w_shifted[M-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_k              <= 3'd0;
            r_commit_pending <= 1'b0;
            r_out_valid      <= 1'b0;
            r_out_data       <= '0;
            r_ovf            <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_shadow[i] <= (i % 5 == 0) ? c_one : '0;
                r_active[i] <= (i % 5 == 0) ? c_one : '0;
            end
            for (int r = 0; r < 4; r++) begin
                r_vec[r] <= '0;
                r_acc[r] <= '0;
            end
        end else begin
            if (mat_we) begin
                r_shadow[mat_addr] <= mat_data;
            end

            if (mat_commit) begin
                r_commit_pending <= 1'b1;
            end else if (w_copy) begin
                r_commit_pending <= 1'b0;
            end

            if (w_copy) begin
                for (int i = 0; i < 16; i++) begin
                    r_active[i] <= r_shadow[i];
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        for (int c = 0; c < 4; c++) begin
                            r_vec[c] <= in_data[c*W +: W];
                            r_acc[c] <= '0;
                        end
                        r_k     <= 3'd0;
                        r_state <= S_ACC;
                    end
                end
                S_ACC: begin
                    // k = 0..3 accumulate; the extra k = 4 cycle formats the final sums.
                    if (r_k == 3'd4) begin
                        r_out_data  <= w_result;
                        r_out_valid <= 1'b1;
                        if (|w_ovf) begin
                            r_ovf <= 1'b1;
                        end
                        r_state <= S_OUT;
                    end else begin
                        for (int r = 0; r < 4; r++) begin
                            r_acc[r] <= r_acc[r] + w_prod_ext[r];
                        end
                        r_k <= r_k + 3'd1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vertex_transform_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_vertex_transform_unit
// Brief    : Self-checking bench for vertex_transform_unit against a
//            behavioural matrix-vector reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vertex_transform_unit;

    localparam int M   = 11;
    localparam int N   = 7;
    localparam int W   = M + N;
    localparam bit SAT = 1'b1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             mat_we = 1'b0;
    logic [3:0]       mat_addr = '0;
    logic [W-1:0]     mat_data = '0;
    logic             mat_commit = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [4*W-1:0]   in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [4*M-1:0]   out_data;
    logic             busy;
    logic             ovf;

    int     checks = 0;
    int     errors = 0;
    longint mdl_shadow [16];
    longint mdl_active [16];
    bit     exp_ovf;

    vertex_transform_unit #(.M(M), .N(N), .SATURATE(SAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .mat_we     (mat_we),
        .mat_addr   (mat_addr),
        .mat_data   (mat_data),
        .mat_commit (mat_commit),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    function automatic longint comp(input logic [4*W-1:0] v, input int c);
        logic [W-1:0] t;
        t = v[c*W +: W];
        return longint'($signed(t));
    endfunction

    function automatic logic [4*W-1:0] pack_vec(input longint a, input longint b,
                                                input longint c, input longint d);
        return {W'(d), W'(c), W'(b), W'(a)};
    endfunction

    function automatic logic [4*M-1:0] pack_out(input longint a, input longint b,
                                                input longint c, input longint d);
        return {M'(d), M'(c), M'(b), M'(a)};
    endfunction

    // Reference: exact dot products, floor division by 2^(2N), then clamp or wrap.
    function automatic logic [4*M-1:0] model_out(input logic [4*W-1:0] v, output bit ov);
        logic [4*M-1:0] res;
        longint sum, q;
        longint hi = (64'sd1 <<< (M - 1)) - 1;
        longint lo = -(64'sd1 <<< (M - 1));
        ov = 1'b0;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            sum = 0;
            for (int k = 0; k < 4; k++) sum += mdl_active[4*r+k] * comp(v, k);
            q = sum >>> (2 * N);
            if (q > hi || q < lo) begin
                ov = 1'b1;
                if (SAT) q = (q > hi) ? hi : lo;
            end
            res[r*M +: M] = M'(q);
        end
        return res;
    endfunction

    function automatic longint rnd(input int span);
        return longint'($urandom_range(2 * span, 0)) - longint'(span);
    endfunction

    task automatic model_identity();
        for (int i = 0; i < 16; i++) begin
            mdl_shadow[i] = (i % 5 == 0) ? (64'sd1 <<< N) : 0;
            mdl_active[i] = mdl_shadow[i];
        end
        exp_ovf = 1'b0;
    endtask

    task automatic write_mat(input int a, input longint d);
        mat_we = 1'b1; mat_addr = 4'(a); mat_data = W'(d);
        @(negedge clk);
        mat_we = 1'b0;
        mdl_shadow[a] = d;
    endtask

    task automatic commit_mat(output bit ok);
        mat_commit = 1'b1;
        @(negedge clk);
        mat_commit = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (!busy) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) mdl_active = mdl_shadow;
    endtask

    task automatic send_vertex(input logic [4*W-1:0] v, output bit ok);
        in_valid = 1'b1; in_data = v; ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (in_ready) begin ok = 1'b1; @(negedge clk); break; end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc, output bit ok);
        cyc = 0; ok = 1'b0;
        while (cyc < 40) begin
            if (out_valid) begin ok = 1'b1; break; end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b need 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b need 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h need 0", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b need 0", busy); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b need 0", ovf); end
        rst = 1'b0;
        model_identity();
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b need 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_identity();
        logic [4*W-1:0] v;
        logic [4*M-1:0] exp_d;
        bit ok, ov;
        int cyc;
        v = pack_vec(384, -320, 1280, 128);
        exp_d = model_out(v, ov);
        out_ready = 1'b1;
        send_vertex(v, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ident_accept: got timeout need handshake"); end
        wait_out(cyc, ok);
        checks++; if (!ok || cyc != 5) begin errors++; $display("FAIL ident_latency: got %0d need 5", cyc); end
        checks++; if (out_data !== pack_out(3, -3, 10, 1)) begin errors++; $display("FAIL ident_data: got %h need %h", out_data, pack_out(3, -3, 10, 1)); end
        checks++; if (out_data !== exp_d) begin errors++; $display("FAIL ident_model: got %h need %h", out_data, exp_d); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ident_ovf: got %b need 0", ovf); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ident_ready_after: got %b need 1", in_ready); end
    endtask

    task automatic test_translate();
        bit ok;
        int cyc;
        write_mat(0, 128); write_mat(5, 128); write_mat(10, 128); write_mat(15, 128);
        write_mat(3, 640);
        commit_mat(ok);
        checks++; if (!ok) begin errors++; $display("FAIL xlate_commit: got busy need idle"); end
        send_vertex(pack_vec(384, -320, 1280, 128), ok);
        wait_out(cyc, ok);
        checks++; if (!ok || out_data !== pack_out(8, -3, 10, 1)) begin errors++; $display("FAIL xlate_data: got %h need %h", out_data, pack_out(8, -3, 10, 1)); end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        logic [4*W-1:0] v;
        logic [4*M-1:0] exp_d;
        bit ok, ov;
        int cyc;
        write_mat(0, 1024);
        commit_mat(ok);
        v = pack_vec(38400, 0, 0, 0);
        exp_d = model_out(v, ov);
        exp_ovf |= ov;
        send_vertex(v, ok);
        wait_out(cyc, ok);
        checks++; if (!ok || out_data !== pack_out(SAT ? 1023 : 352, 0, 0, 0)) begin errors++; $display("FAIL ovf_data: got %h need %h", out_data, pack_out(SAT ? 1023 : 352, 0, 0, 0)); end
        checks++; if (out_data !== exp_d) begin errors++; $display("FAIL ovf_model: got %h need %h", out_data, exp_d); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b need 1", ovf); end
        @(negedge clk);
    endtask

    task automatic test_shadow_isolation();
        logic [4*W-1:0] v1, v2;
        logic [4*M-1:0] exp_d;
        bit ok, ov;
        int cyc;
        write_mat(0, 128); write_mat(3, 0);
        commit_mat(ok);
        v1 = pack_vec(rnd(3000), rnd(3000), rnd(3000), rnd(3000));
        exp_d = model_out(v1, ov);
        send_vertex(v1, ok);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL shadow_ready_acc: got %b need 0", in_ready); end
        mat_we = 1'b1; mat_addr = 4'd5; mat_data = W'(256); mat_commit = 1'b1;
        @(negedge clk);
        mat_we = 1'b0; mat_commit = 1'b0;
        mdl_shadow[5] = 256;
        wait_out(cyc, ok);
        checks++; if (!ok || out_data !== exp_d) begin errors++; $display("FAIL shadow_old_matrix: got %h need %h", out_data, exp_d); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL shadow_hold: got ready=%b busy=%b need ready=0 busy=1", in_ready, busy); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL shadow_ready_rise: got %b need 1", in_ready); end
        mdl_active = mdl_shadow;
        v2 = pack_vec(rnd(3000), rnd(3000), rnd(3000), rnd(3000));
        exp_d = model_out(v2, ov);
        send_vertex(v2, ok);
        wait_out(cyc, ok);
        checks++; if (!ok || out_data !== exp_d) begin errors++; $display("FAIL shadow_new_matrix: got %h need %h", out_data, exp_d); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [4*W-1:0] v;
        logic [4*M-1:0] exp_d, held;
        bit ok, ov;
        int cyc, stall;
        v = pack_vec(rnd(5000), rnd(5000), rnd(5000), rnd(5000));
        exp_d = model_out(v, ov);
        exp_ovf |= ov;
        out_ready = 1'b0;
        send_vertex(v, ok);
        wait_out(cyc, ok);
        held = out_data;
        checks++; if (!ok || held !== exp_d) begin errors++; $display("FAIL bp_data: got %h need %h", held, exp_d); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (out_data !== held || in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold: got data=%h ready=%b valid=%b need data=%h ready=0 valid=1", out_data, in_ready, out_valid, held); end
        end
        out_ready = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) write_mat(i, rnd(512));
        commit_mat(ok);
        for (int n = 0; n < 8; n++) begin
            v = pack_vec(rnd(20000), rnd(20000), rnd(20000), rnd(20000));
            exp_d = model_out(v, ov);
            exp_ovf |= ov;
            stall = int'($urandom_range(3, 0));
            out_ready = 1'b0;
            send_vertex(v, ok);
            checks++; if (!ok) begin errors++; $display("FAIL stream_accept_%0d: got timeout need handshake", n); end
            wait_out(cyc, ok);
            repeat (stall) @(negedge clk);
            checks++; if (!ok || out_data !== exp_d || ovf !== exp_ovf) begin errors++; $display("FAIL stream_%0d: got data=%h ovf=%b need data=%h ovf=%b", n, out_data, ovf, exp_d, exp_ovf); end
            out_ready = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_acc();
        bit ok, seen;
        int cyc;
        out_ready = 1'b1;
        send_vertex(pack_vec(rnd(3000), rnd(3000), rnd(3000), rnd(3000)), ok);
        @(negedge clk);
        mat_we = 1'b1; mat_addr = 4'd0; mat_data = W'(300); mat_commit = 1'b1;
        @(negedge clk);
        mat_we = 1'b0; mat_commit = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstacc_ready: got %b need 0", in_ready); end
        checks++; if (out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL rstacc_state: got valid=%b data=%h busy=%b ovf=%b need all 0", out_valid, out_data, busy, ovf); end
        rst = 1'b0;
        model_identity();
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstacc_no_output: got out_valid=1 need 0"); end
        send_vertex(pack_vec(384, -320, 1280, 128), ok);
        wait_out(cyc, ok);
        checks++; if (!ok || out_data !== pack_out(3, -3, 10, 1)) begin errors++; $display("FAIL rstacc_identity: got %h need %h", out_data, pack_out(3, -3, 10, 1)); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_translate();
        test_overflow();
        test_shadow_isolation();
        test_backpressure();
        test_reset_mid_acc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
